flags_ctrl: RTL and testbench
=============================

# flags_ctrl

Owns the architectural NZCVQ flags register of the pipelined core. Evaluates the condition of the Execute-stage instruction and commits single-cycle ALU flag results under the three-group write mask. Tracks one outstanding multi-cycle flag writer (multiply unit) and stalls Decode on flag hazards until that writer completes. Provides a one-entry save/restore shadow for exception entry and return.

## Interface
- TIMEOUT, 32: maximum cycles to wait for MultiDone before abandoning the pending write; must be ≥1.
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ValidE  in  1  Execute holds a real instruction (0 = bubble or flushed)
- CondE  in  4  condition field of the Execute instruction
- FlagsWriteE  in  3  group mask: [2]=N,Z  [1]=C,V  [0]=Q
- MultiE  in  1  Execute instruction's flags come later from the multi-cycle unit
- ALUFlagsE  in  5  {N,Z,C,V,Q} from the single-cycle ALU
- MultiDone  in  1  multi-cycle result valid this cycle
- MultiFlags  in  5  {N,Z,C,V,Q} from the multi-cycle unit
- ReadsFlagsD  in  1  Decode instruction is conditional (not AL) or consumes carry
- WritesFlagsD  in  1  Decode instruction has a nonzero flag write mask
- SaveFlags  in  1  copy Flags into shadow (exception entry)
- RestoreFlags  in  1  copy shadow into Flags (exception return / flush)
- Flags  out  5  architectural {N,Z,C,V,Q}, registered
- SavedFlags  out  5  shadow register
- CondExE  out  1  Execute condition passes, combinational
- StallD  out  1  hold Decode this cycle
- Busy  out  1  multi-cycle flag write outstanding (state WAIT)
- Timeout  out  1  sticky error; multi-cycle write abandoned

## Operation
- CondExE is a function of Flags and CondE: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE (N==V), LT, GT, LE, AL=1. Code 1111 gives 0.
- Commit condition: ValidE & CondExE & FlagsWriteE≠0.
- State RUN:
  - Commit with MultiE=0: each group whose mask bit is set loads from ALUFlagsE; the other groups hold.
  - Commit with MultiE=1: latch FlagsWriteE into PendMask, load the counter with TIMEOUT, and go to WAIT. Flags hold.
  - MultiDone in RUN is ignored.
- State WAIT:
  - StallD = ReadsFlagsD | WritesFlagsD.
  - MultiDone: masked groups load from MultiFlags, clear PendMask, go to RUN.
  - Otherwise the counter decrements. If the counter reaches 0 without MultiDone, set Timeout, go to RUN, and leave Flags unchanged.
  - MultiDone on the same cycle the counter reaches 0: the done path wins and Timeout is not set.
  - ValidE instructions in WAIT do not commit; Decode stalling prevents them.
- SaveFlags: SavedFlags ← current Flags (the pre-edge value).
- RestoreFlags: Flags ← SavedFlags (the pre-edge value). This overrides any ALU or multi-cycle update that cycle, aborts WAIT to RUN, and clears PendMask. Timeout is not set.
- SaveFlags and RestoreFlags together: Flags and SavedFlags swap.
- Timeout clears only on reset.

## Timing
- Reset values: Flags=0, SavedFlags=0, state RUN, PendMask=0, counter=0, Timeout=0. Therefore StallD=0, Busy=0, and CondExE = f(0, CondE).
- The reset assertion is asynchronous and takes effect mid-WAIT; the pending write is lost.
- CondExE and StallD are combinational, zero latency.
- Flag updates are visible on Flags one cycle after the commit edge. A back-to-back flag setter followed by a conditional instruction in Execute sees the new flags with no bubble.
- Multi-cycle latency is 1..TIMEOUT cycles after entering WAIT. Busy rises the cycle after the MultiE commit and falls the cycle after MultiDone.

## Structure
- Shared package holds:
  - condition-code constants COND_EQ..COND_AL
  - flag bit indices FLAG_N..FLAG_Q
  - group mask constants GRP_NZ, GRP_CV, GRP_Q
  - state enum {RUN, WAIT}
- Counter width is $clog2(TIMEOUT+1).
- One sub-module is natural: cond_eval, a combinational evaluation of CondE against Flags producing CondExE.
- The masked merge is a local function reused for the ALU and multi-cycle paths.

## Test plan
- Reset, then ValidE=1, CondE=AL, FlagsWriteE=100, ALUFlagsE=11111, MultiE=0 → next cycle Flags=11000; CondE=EQ then gives CondExE=1.
- Flags=01000, CondE=NE, FlagsWriteE=111 → CondExE=0 and Flags unchanged. With ValidE=0 and CondE=AL, Flags are also unchanged.
- MultiE commit with mask 010, ReadsFlagsD=1 → StallD=1 and Busy=1. MultiDone three cycles later with MultiFlags=00110 → only C,V are updated, and StallD=0 the cycle after.
- TIMEOUT=4, MultiE commit, no MultiDone → Timeout=1 after 4 WAIT cycles, state RUN, Flags unchanged. Repeat with MultiDone on the 4th cycle → Flags updated and Timeout=0.
- Flags=10000, SavedFlags=00101, SaveFlags=RestoreFlags=1 on the same edge as an ALU commit → Flags=00101 and SavedFlags=10000.
- In WAIT, RestoreFlags=1 → state RUN, a later MultiDone is ignored, StallD=0.

Source files
------------

// File: rtl/flags_ctrl_pkg.sv
// rtl/flags_ctrl_pkg.sv - shared constants and types for the NZCVQ flags controller
package flags_ctrl_pkg;

    // Condition-code field encodings (1111 never passes)
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Bit positions within the {N,Z,C,V,Q} flags vector
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Q = 0;

    // Write-mask groups
    localparam logic [2:0] GRP_NZ = 3'b100;
    localparam logic [2:0] GRP_CV = 3'b010;
    localparam logic [2:0] GRP_Q  = 3'b001;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/flags_ctrl_cond_eval.sv
// rtl/flags_ctrl_cond_eval.sv - combinational condition-code evaluation against N,Z,C,V
module flags_ctrl_cond_eval
    import flags_ctrl_pkg::*;
(
    input  logic [3:0] i_nzcv,
    input  logic [3:0] i_cond,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_nzcv[3];
    assign w_z = i_nzcv[2];
    assign w_c = i_nzcv[1];
    assign w_v = i_nzcv[0];

    // Decode the condition field into a pass/fail for the Execute instruction
    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flags_ctrl.sv
// rtl/flags_ctrl.sv - architectural NZCVQ flags register with multi-cycle writer tracking and shadow
module flags_ctrl
    import flags_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_valid_e,
    input  logic [3:0] i_cond_e,
    input  logic [2:0] i_flags_write_e,
    input  logic       i_multi_e,
    input  logic [4:0] i_alu_flags_e,
    input  logic       i_multi_done,
    input  logic [4:0] i_multi_flags,
    input  logic       i_reads_flags_d,
    input  logic       i_writes_flags_d,
    input  logic       i_save_flags,
    input  logic       i_restore_flags,
    output logic [4:0] o_flags,
    output logic [4:0] o_saved_flags,
    output logic       o_cond_ex_e,
    output logic       o_stall_d,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          r_state;
    logic [4:0]      r_flags;
    logic [4:0]      r_saved;
    logic [2:0]      r_pend_mask;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;
    logic            w_cond_pass;
    logic            w_commit;

    // Load only the groups selected by the mask; unselected groups keep their old value
    function automatic logic [4:0] merge_flags(input logic [4:0] old_f,
                                               input logic [4:0] new_f,
                                               input logic [2:0] mask);
        logic [4:0] r;
        r = old_f;
        if (|(mask & GRP_NZ)) begin
            r[FLAG_N] = new_f[FLAG_N];
            r[FLAG_Z] = new_f[FLAG_Z];
        end
        if (|(mask & GRP_CV)) begin
            r[FLAG_C] = new_f[FLAG_C];
            r[FLAG_V] = new_f[FLAG_V];
        end
        if (|(mask & GRP_Q)) begin
            r[FLAG_Q] = new_f[FLAG_Q];
        end
        return r;
    endfunction

    flags_ctrl_cond_eval u_cond_eval (
        .i_nzcv (r_flags[FLAG_N:FLAG_V]),
        .i_cond (i_cond_e),
        .o_pass (w_cond_pass)
    );

    assign w_commit      = i_valid_e & w_cond_pass & (i_flags_write_e != 3'b000);
    assign o_cond_ex_e   = w_cond_pass;
    assign o_busy        = (r_state == WAIT);
    assign o_stall_d     = o_busy & (i_reads_flags_d | i_writes_flags_d);
    assign o_flags       = r_flags;
    assign o_saved_flags = r_saved;
    assign o_timeout     = r_timeout;

    // Flags/shadow update and RUN/WAIT sequencing; restore overrides every other writer
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= RUN;
            r_flags     <= 5'b00000;
            r_saved     <= 5'b00000;
            r_pend_mask <= 3'b000;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (i_save_flags) begin
                r_saved <= r_flags;
            end
            if (i_restore_flags) begin
                r_flags     <= r_saved;
                r_state     <= RUN;
                r_pend_mask <= 3'b000;
                r_cnt       <= '0;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_commit) begin
                            if (i_multi_e) begin
                                r_pend_mask <= i_flags_write_e;
                                r_cnt       <= CW'(TIMEOUT);
                                r_state     <= WAIT;
                            end else begin
                                r_flags <= merge_flags(r_flags, i_alu_flags_e, i_flags_write_e);
                            end
                        end
                    end
                    WAIT: begin
                        if (i_multi_done) begin
                            r_flags     <= merge_flags(r_flags, i_multi_flags, r_pend_mask);
                            r_pend_mask <= 3'b000;
                            r_cnt       <= '0;
                            r_state     <= RUN;
                        end else if (r_cnt <= CW'(1)) begin
                            r_timeout   <= 1'b1;
                            r_pend_mask <= 3'b000;
                            r_cnt       <= '0;
                            r_state     <= RUN;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flags_ctrl.sv
// tb/tb_flags_ctrl.sv - self-checking bench for flags_ctrl with a behavioural reference model
module tb_flags_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       valid_e = 1'b0;
    logic [3:0] cond_e = 4'b1110;
    logic [2:0] we_e = 3'b000;
    logic       multi_e = 1'b0;
    logic [4:0] alu_e = 5'b00000;
    logic       mdone = 1'b0;
    logic [4:0] mflags = 5'b00000;
    logic       reads_d = 1'b0;
    logic       writes_d = 1'b0;
    logic       save = 1'b0;
    logic       restore = 1'b0;
    logic [4:0] flags;
    logic [4:0] saved;
    logic       cond_ex;
    logic       stall;
    logic       busy;
    logic       tmo;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [4:0] m_flags, m_saved, m_pmask;
    bit         m_pend, m_to;
    int         m_elapsed;

    flags_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid_e(valid_e), .i_cond_e(cond_e),
        .i_flags_write_e(we_e), .i_multi_e(multi_e), .i_alu_flags_e(alu_e),
        .i_multi_done(mdone), .i_multi_flags(mflags), .i_reads_flags_d(reads_d),
        .i_writes_flags_d(writes_d), .i_save_flags(save), .i_restore_flags(restore),
        .o_flags(flags), .o_saved_flags(saved), .o_cond_ex_e(cond_ex),
        .o_stall_d(stall), .o_busy(busy), .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    function automatic bit model_cond(input logic [4:0] f, input logic [3:0] c);
        bit n, z, cy, v, r;
        n = f[4]; z = f[3]; cy = f[2]; v = f[1];
        case (c)
            4'd0:  r = z;
            4'd1:  r = !z;
            4'd2:  r = cy;
            4'd3:  r = !cy;
            4'd4:  r = n;
            4'd5:  r = !n;
            4'd6:  r = v;
            4'd7:  r = !v;
            4'd8:  r = cy && !z;
            4'd9:  r = !cy || z;
            4'd10: r = (n == v);
            4'd11: r = (n != v);
            4'd12: r = !z && (n == v);
            4'd13: r = z || (n != v);
            4'd14: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Bit i of {N,Z,C,V,Q} belongs to mask group 2 (N,Z), 1 (C,V) or 0 (Q)
    function automatic logic [4:0] model_merge(input logic [4:0] o, input logic [4:0] n,
                                               input logic [4:0] mask);
        logic [4:0] r;
        int g;
        r = o;
        for (int i = 0; i < 5; i++) begin
            g = (i == 0) ? 0 : ((i <= 2) ? 1 : 2);
            if (mask[g]) r[i] = n[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_flags = 0; m_saved = 0; m_pmask = 0; m_pend = 0; m_to = 0; m_elapsed = 0;
    endtask

    task automatic idle();
        valid_e = 0; cond_e = 4'b1110; we_e = 0; multi_e = 0; alu_e = 0;
        mdone = 0; mflags = 0; reads_d = 0; writes_d = 0; save = 0; restore = 0;
    endtask

    // Advance one clock edge, stepping the model with the inputs presented before the edge
    task automatic tick();
        logic [4:0] nf, ns;
        nf = m_flags;
        ns = save ? m_flags : m_saved;
        if (restore) begin
            nf = m_saved; m_pend = 0; m_elapsed = 0;
        end else if (m_pend) begin
            if (mdone) begin
                nf = model_merge(m_flags, mflags, m_pmask); m_pend = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == TO) begin m_to = 1; m_pend = 0; end
            end
        end else if (valid_e && model_cond(m_flags, cond_e) && we_e != 0) begin
            if (multi_e) begin m_pend = 1; m_pmask = {2'b00, we_e}; m_elapsed = 0; end
            else nf = model_merge(m_flags, alu_e, {2'b00, we_e});
        end
        @(posedge clk);
        m_flags = nf; m_saved = ns;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        idle();
        model_reset();
        @(negedge clk);
        reset_n = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        reads_d = 1; writes_d = 1; cond_e = 4'b0000;
        #1;
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags got %b exp 00000", flags); end
        checks++; if (saved !== 5'b00000) begin errors++; $display("FAIL reset_saved got %b exp 00000", saved); end
        checks++; if (busy !== 1'b0 || stall !== 1'b0 || tmo !== 1'b0) begin errors++; $display("FAIL reset_ctrl got busy=%b stall=%b tmo=%b exp 0 0 0", busy, stall, tmo); end
        checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL reset_cond_eq got %b exp 0", cond_ex); end
        cond_e = 4'b0001; #1;
        checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL reset_cond_ne got %b exp 1", cond_ex); end
        cond_e = 4'b1111; #1;
        checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL reset_cond_nv got %b exp 0", cond_ex); end
        idle();
    endtask

    task automatic test_alu_commit();
        valid_e = 1; cond_e = 4'b1110; we_e = 3'b100; alu_e = 5'b11111;
        tick();
        idle();
        checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL alu_commit got %b exp 11000", flags); end
        cond_e = 4'b0000; #1;
        checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL alu_cond_eq got %b exp 1", cond_ex); end
        idle();
    endtask

    task automatic test_cond_fail();
        valid_e = 1; cond_e = 4'b1110; we_e = 3'b111; alu_e = 5'b01000;
        tick();
        cond_e = 4'b0001; alu_e = 5'b11111; #1;
        checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL cond_ne got %b exp 0", cond_ex); end
        tick();
        checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL cond_fail_hold got %b exp 01000", flags); end
        valid_e = 0; cond_e = 4'b1110;
        tick();
        checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL bubble_hold got %b exp 01000", flags); end
        idle();
    endtask

    task automatic test_multi();
        valid_e = 1; cond_e = 4'b1110; multi_e = 1; we_e = 3'b010; alu_e = 5'b11111;
        tick();
        idle();
        reads_d = 1; #1;
        checks++; if (stall !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL multi_stall got stall=%b busy=%b exp 1 1", stall, busy); end
        checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL multi_hold got %b exp 01000", flags); end
        tick();
        tick();
        mdone = 1; mflags = 5'b00110;
        tick();
        mdone = 0;
        checks++; if (flags !== 5'b01110) begin errors++; $display("FAIL multi_done got %b exp 01110", flags); end
        checks++; if (stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL multi_release got stall=%b busy=%b exp 0 0", stall, busy); end
        idle();
    endtask

    task automatic test_timeout();
        valid_e = 1; multi_e = 1; we_e = 3'b111;
        tick();
        idle();
        for (int i = 0; i < TO - 1; i++) tick();
        checks++; if (busy !== 1'b1 || tmo !== 1'b0) begin errors++; $display("FAIL timeout_early got busy=%b tmo=%b exp 1 0", busy, tmo); end
        tick();
        checks++; if (busy !== 1'b0 || tmo !== 1'b1 || flags !== 5'b01110) begin errors++; $display("FAIL timeout got busy=%b tmo=%b flags=%b exp 0 1 01110", busy, tmo, flags); end
        do_reset();
        valid_e = 1; multi_e = 1; we_e = 3'b111;
        tick();
        idle();
        for (int i = 0; i < TO - 1; i++) tick();
        mdone = 1; mflags = 5'b10101;
        tick();
        idle();
        checks++; if (flags !== 5'b10101 || tmo !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_at_limit got flags=%b tmo=%b busy=%b exp 10101 0 0", flags, tmo, busy); end
    endtask

    task automatic test_swap();
        valid_e = 1; we_e = 3'b111; alu_e = 5'b00101;
        tick();
        valid_e = 0; save = 1;
        tick();
        save = 0; valid_e = 1; alu_e = 5'b10000;
        tick();
        save = 1; restore = 1; alu_e = 5'b11111;
        tick();
        idle();
        checks++; if (flags !== 5'b00101 || saved !== 5'b10000) begin errors++; $display("FAIL swap got flags=%b saved=%b exp 00101 10000", flags, saved); end
    endtask

    task automatic test_restore_in_wait();
        valid_e = 1; multi_e = 1; we_e = 3'b111;
        tick();
        idle();
        restore = 1;
        tick();
        restore = 0; reads_d = 1; #1;
        checks++; if (busy !== 1'b0 || stall !== 1'b0 || flags !== 5'b10000) begin errors++; $display("FAIL restore_wait got busy=%b stall=%b flags=%b exp 0 0 10000", busy, stall, flags); end
        mdone = 1; mflags = 5'b01010;
        tick();
        idle();
        checks++; if (flags !== 5'b10000 || tmo !== 1'b0) begin errors++; $display("FAIL late_done got flags=%b tmo=%b exp 10000 0", flags, tmo); end
    endtask

    task automatic test_back_to_back();
        valid_e = 1; we_e = 3'b100; alu_e = 5'b01000;
        tick();
        cond_e = 4'b0000; we_e = 3'b010; alu_e = 5'b00110; #1;
        checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL b2b_cond got %b exp 1", cond_ex); end
        tick();
        idle();
        checks++; if (flags !== 5'b01110) begin errors++; $display("FAIL b2b_flags got %b exp 01110", flags); end
    endtask

    task automatic test_async_reset();
        valid_e = 1; multi_e = 1; we_e = 3'b011;
        tick();
        idle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b exp 1", busy); end
        @(negedge clk);
        reset_n = 0; #1;
        model_reset();
        checks++; if (busy !== 1'b0 || flags !== 5'b00000 || saved !== 5'b00000) begin errors++; $display("FAIL async_reset got busy=%b flags=%b saved=%b exp 0 00000 00000", busy, flags, saved); end
        @(negedge clk);
        reset_n = 1; #1;
    endtask

    task automatic test_random();
        bit exp_cond;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            valid_e  = ($urandom_range(0, 3) != 0);
            cond_e   = 4'($urandom_range(0, 15));
            we_e     = 3'($urandom_range(0, 7));
            multi_e  = ($urandom_range(0, 3) == 0);
            alu_e    = 5'($urandom);
            mdone    = ($urandom_range(0, 2) == 0);
            mflags   = 5'($urandom);
            reads_d  = 1'($urandom);
            writes_d = 1'($urandom);
            save     = ($urandom_range(0, 15) == 0);
            restore  = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            exp_cond = model_cond(m_flags, cond_e);
            checks++;
            if (flags !== m_flags || saved !== m_saved || cond_ex !== exp_cond || busy !== m_pend
                || stall !== (m_pend && (reads_d || writes_d)) || tmo !== m_to) begin
                errors++;
                $display("FAIL random[%0d] got f=%b s=%b c=%b b=%b st=%b t=%b exp f=%b s=%b c=%b b=%b st=%b t=%b",
                         n, flags, saved, cond_ex, busy, stall, tmo, m_flags, m_saved, exp_cond,
                         m_pend, m_pend && (reads_d || writes_d), m_to);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_alu_commit();
        test_cond_fail();
        test_multi();
        test_timeout();
        test_swap();
        test_restore_in_wait();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
